// File: rtl/comp_pkg.sv
// Shared codes and state encodings for the wide-word comparator cascade.
package comp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/comp_code_decode.sv
// Priority decode of one nibble comparator code into a clean one-hot code.
// The one-hot legality check exists only when COMP_ONEHOT_CHECK_EN is defined.
module comp_code_decode
    import comp_pkg::*;
(
    input  logic [2:0] cmp_in,
    output logic [2:0] dec_code
`ifdef COMP_ONEHOT_CHECK_EN
    ,
    output logic       illegal
`endif
);

    // gt wins over lt, and an all-zero code reads as equal
    always_comb begin
        dec_code = CMP_EQ;
        if (cmp_in[2]) begin
            dec_code = CMP_GT;
        end else if (cmp_in[1]) begin
            dec_code = CMP_LT;
        end
    end

`ifdef COMP_ONEHOT_CHECK_EN
    assign illegal = (cmp_in != CMP_GT) && (cmp_in != CMP_LT) && (cmp_in != CMP_EQ);
`endif

endmodule

// File: rtl/comp_cascade_seq.sv
// Folds NIBBLES per-nibble compare codes (MSB nibble first) into one wide-word result.
// Optional one-hot checking of incoming codes is enabled by COMP_ONEHOT_CHECK_EN.
module comp_cascade_seq
    import comp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 cmp_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 result,
    output logic                       err,
    output logic [$clog2(NIBBLES)-1:0] beat_cnt
);

    localparam int W = $clog2(NIBBLES);
    localparam logic [W-1:0] LAST_BEAT = W'(NIBBLES - 1);

    state_e     state_reg;
    logic [W-1:0] beat_cnt_reg;
    logic [2:0] dec_reg;
    logic [2:0] dec_next;
    logic [2:0] result_reg;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic [2:0] dec_code;
    logic       keep_dec;
    logic       accept;
    logic       last_beat;

    assign accept    = in_valid & in_ready_reg;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

`ifdef COMP_ONEHOT_CHECK_EN
    logic illegal;
    logic flag_reg;
    logic flag_next;
    logic err_reg;

    comp_code_decode u_decode (
        .cmp_in   (cmp_in),
        .dec_code (dec_code),
        .illegal  (illegal)
    );

    // an illegal code behaves like EQ, so it can never decide the word
    assign keep_dec  = (dec_reg != CMP_EQ) || illegal;
    assign flag_next = flag_reg | illegal;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else if ((state_reg == ST_ACC) && accept) begin
            if (last_beat) begin
                err_reg  <= flag_next;
                flag_reg <= 1'b0;
            end else begin
                flag_reg <= flag_next;
            end
        end
    end
`else
    comp_code_decode u_decode (
        .cmp_in   (cmp_in),
        .dec_code (dec_code)
    );

    assign keep_dec = (dec_reg != CMP_EQ);
    assign err      = 1'b0;
`endif

    // the first unequal nibble locks the decision for the rest of the word
    assign dec_next = keep_dec ? dec_reg : dec_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACC;
            beat_cnt_reg  <= '0;
            dec_reg       <= CMP_EQ;
            result_reg    <= 3'b000;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_cnt_reg  <= '0;
                            result_reg    <= dec_next;
                            dec_reg       <= CMP_EQ;
                            state_reg     <= ST_HOLD;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + W'(1);
                            dec_reg      <= dec_next;
                        end
                    end
                end
                ST_HOLD: begin
                    // the handshake cycle is the bubble: in_ready is still low here
                    if (out_ready) begin
                        state_reg     <= ST_ACC;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_ACC;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_comp_cascade_seq.sv
// Scoreboard bench for comp_cascade_seq with NIBBLES=4; honours COMP_ONEHOT_CHECK_EN.
module tb_comp_cascade_seq;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] cmp_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] result;
    logic       err;
    logic [1:0] beat_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int results_seen = 0;
    int results_expected = 0;
    logic [3:0] sb_q[$];

    comp_cascade_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmp_in    (cmp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // reference: first unequal legal nibble decides; {err, result}
    function automatic logic [3:0] model(input logic [N-1:0][2:0] w);
        logic [2:0] d;
        logic e;
        logic [2:0] c;
        d = 3'b001;
        e = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = w[i];
`ifdef COMP_ONEHOT_CHECK_EN
            if (!(c == 3'b100 || c == 3'b010 || c == 3'b001)) e = 1'b1;
            else if (d == 3'b001) d = c;
`else
            if (d == 3'b001) d = c[2] ? 3'b100 : (c[1] ? 3'b010 : 3'b001);
`endif
        end
        return {e, d};
    endfunction

    function automatic logic [N-1:0][2:0] mkw(input logic [2:0] a, input logic [2:0] b,
                                               input logic [2:0] c, input logic [2:0] d);
        logic [N-1:0][2:0] w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w;
    endfunction

    // monitor: a result transfers at the next posedge when valid&ready seen here
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [3:0] exp;
            results_seen++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                check("result", result, exp[2:0]);
                check("err", err, exp[3]);
            end
        end
    end

    // enter from posedge+1; leaves at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] code, input int gap);
        logic ok;
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        cmp_in = code;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("accept_timeout", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0][2:0] w, input int maxgap);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                sb_q.push_back(model(w));
                results_expected++;
            end
            send(w[i], (maxgap == 0) ? 0 : $urandom_range(maxgap, 0));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0][2:0] w;
        rst = 1'b1;
        in_valid = 1'b0;
        cmp_in = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_beat_cnt", beat_cnt, 0);

        // back-to-back word, latency and single-cycle hold with out_ready=1
        send_word(mkw(3'b001, 3'b001, 3'b100, 3'b010), 0);
        check("t1_out_valid_hi", out_valid, 1);
        check("t1_in_ready_lo", in_ready, 0);
        @(posedge clk); #1;
        check("t1_out_valid_lo", out_valid, 0);
        check("t1_in_ready_hi", in_ready, 1);
        drain();

        send_word(mkw(3'b001, 3'b001, 3'b001, 3'b001), 0);
        send_word(mkw(3'b010, 3'b100, 3'b100, 3'b100), 0);
        drain();

        // backpressure in HOLD, inputs ignored
        out_ready = 1'b0;
        send_word(mkw(3'b100, 3'b010, 3'b001, 3'b010), 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            cmp_in = 3'b010;
            check("t3_out_valid", out_valid, 1);
            check("t3_result", result, 3'b100);
            check("t3_in_ready", in_ready, 0);
            check("t3_beat_cnt", beat_cnt, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_after_out_valid", out_valid, 0);
        check("t3_after_beat_cnt", beat_cnt, 0);
        drain();

        // gapped word: in_valid 1,0,0,1,1,0,1
        w = mkw(3'b001, 3'b100, 3'b010, 3'b001);
        send(w[0], 0);
        for (int i = 0; i < 2; i++) begin
            check("t4_gap_beat_cnt", beat_cnt, 1);
            @(posedge clk); #1;
        end
        send(w[1], 0);
        send(w[2], 0);
        check("t4_gap2_beat_cnt", beat_cnt, 3);
        sb_q.push_back(model(w));
        results_expected++;
        send(w[3], 1);
        drain();

        // reset mid-word: GT decided, then abandoned
        send(3'b100, 0);
        send(3'b001, 0);
        check("t5_pre_beat_cnt", beat_cnt, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_out_valid", out_valid, 0);
        check("t5_beat_cnt", beat_cnt, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_result", result, 0);
        send_word(mkw(3'b001, 3'b001, 3'b001, 3'b010), 0);
        drain();

`ifdef COMP_ONEHOT_CHECK_EN
        send_word(mkw(3'b110, 3'b001, 3'b100, 3'b001), 0);
        send_word(mkw(3'b001, 3'b010, 3'b001, 3'b001), 0);
`else
        send_word(mkw(3'b110, 3'b001, 3'b001, 3'b001), 0);
`endif
        drain();

        // random words with random gaps and occasional backpressure
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                w[i] = 3'($urandom_range(7, 0));
                if ($urandom_range(1, 0) == 1) w[i] = 3'b001;
            end
            out_ready = ($urandom_range(2, 0) != 0);
            send_word(w, 2);
            out_ready = 1'b1;
            drain();
        end

        check("sb_empty", sb_q.size(), 0);
        check("result_count", results_seen, results_expected);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
